// File: rtl/instr_byte_fetch.sv
// -----------------------------------------------------------------------------
// instr_byte_fetch
//
// Reads one 32-bit instruction out of the byte-wide, synchronous-read
// instruction RAM. A fetch request issues four consecutive byte reads starting
// at the word-aligned base. The returned bytes are assembled little-endian,
// and the finished word is held behind a valid/ready handshake.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   req_valid    core requests a fetch at req_addr
//   req_ready    request accepted this cycle (IDLE and no flush)
//   req_addr     byte address of the instruction, bits [1:0] ignored
//   flush        abort any fetch in progress and discard its result
//   mem_re       read strobe to the instruction RAM
//   mem_addr     byte address to the instruction RAM
//   mem_rdata    RAM read data, valid the cycle after mem_re/mem_addr
//   instr        assembled instruction word
//   instr_addr   word-aligned byte address of instr
//   instr_valid  instr/instr_addr hold a complete word
//   instr_ready  core consumes the word
//   busy         fetch engine is not idle
// -----------------------------------------------------------------------------
module instr_byte_fetch #(
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  flush,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_rdata,
    output logic [31:0]           instr,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_VALID = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [ADDR_WIDTH-3:0]   word_r;        // word index of the fetch in progress
    logic [1:0]              k_r;           // issue counter
    logic                    cap_en_r;      // a read issued last cycle returns now
    logic [1:0]              cap_idx_r;     // capture counter: byte lane of that read
    logic [23:0]             low_bytes_r;   // bytes 0..2 staged until byte 3 arrives
    logic [31:0]             instr_r;
    logic [ADDR_WIDTH-1:0]   instr_addr_r;
    logic                    accept_s;
    logic                    unused_addr_bits_s;

    // Request handshake and the ignored byte-offset bits of the request address
    assign accept_s           = req_valid & req_ready;
    assign unused_addr_bits_s = ^req_addr[1:0];

    // Base + k never carries out of the low two bits, so concatenation suffices
    assign mem_addr   = {word_r, k_r};
    assign instr      = instr_r;
    assign instr_addr = instr_addr_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; flush takes priority over normal progress in every busy state
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_next_s = S_READ;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_READ: begin
                if (flush) begin
                    state_next_s = S_IDLE;
                end else if (k_r == 2'd3) begin
                    state_next_s = S_DRAIN;
                end else begin
                    state_next_s = S_READ;
                end
            end
            S_DRAIN: begin
                if (flush) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_VALID;
                end
            end
            S_VALID: begin
                if (flush || instr_ready) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_VALID;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Output decode from state; only req_ready also depends on flush
    always_comb begin
        req_ready   = (state_r == S_IDLE) & ~flush;
        mem_re      = (state_r == S_READ);
        instr_valid = (state_r == S_VALID);
        busy        = (state_r != S_IDLE);
    end

    // Fetch base and issue counter
    always_ff @(posedge clk) begin
        if (rst) begin
            word_r <= '0;
            k_r    <= 2'd0;
        end else begin
            if (accept_s) begin
                word_r <= req_addr[ADDR_WIDTH-1:2];
            end else begin
                word_r <= word_r;
            end
            if ((state_r == S_READ) && !flush) begin
                k_r <= k_r + 2'd1;
            end else begin
                k_r <= 2'd0;
            end
        end
    end

    // Byte capture; the word and its address are published only when complete,
    // so an aborted fetch never disturbs the previously held instr/instr_addr
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_en_r     <= 1'b0;
            cap_idx_r    <= 2'd0;
            low_bytes_r  <= 24'd0;
            instr_r      <= 32'd0;
            instr_addr_r <= '0;
        end else begin
            // A read issued in a flush cycle is dropped before its data returns
            cap_en_r  <= (state_r == S_READ) & ~flush;
            cap_idx_r <= k_r;
            if (cap_en_r && !flush) begin
                case (cap_idx_r)
                    2'd0: low_bytes_r[7:0]   <= mem_rdata;
                    2'd1: low_bytes_r[15:8]  <= mem_rdata;
                    2'd2: low_bytes_r[23:16] <= mem_rdata;
                    2'd3: begin
                        instr_r      <= {mem_rdata, low_bytes_r};
                        instr_addr_r <= {word_r, 2'b00};
                    end
                    default: low_bytes_r <= low_bytes_r;
                endcase
            end else begin
                low_bytes_r <= low_bytes_r;
            end
        end
    end

endmodule
